// File: rtl/sme_pkg.sv
// Shared definitions for the string-match engine.
//   CH_*     : byte values with special meaning in text or pattern ROMs
//   state_t  : top-level FSM state encoding
//   fold()   : maps A-Z to a-z when ci is set, any other byte passes through
package sme_pkg;

  localparam logic [7:0] CH_NUL    = 8'h00;
  localparam logic [7:0] CH_SP     = 8'h20;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRE,
    CMP,
    POST,
    EMIT,
    DONE
  } state_t;

  function automatic logic [7:0] fold(input logic [7:0] b, input logic ci);
    return (ci && (b >= 8'h41) && (b <= 8'h5A)) ? (b | 8'h20) : b;
  endfunction

endpackage

// File: rtl/sme_char_cmp.sv
// Single-byte comparator for the match engine.
//   t  : text byte
//   p  : pattern byte (never NUL)
//   ci : fold A-Z to a-z on both sides before comparing
//   eq : 1 when p matches t; '.' matches any byte except NUL
module sme_char_cmp
  import sme_pkg::*;
(
  input  logic [7:0] t,
  input  logic [7:0] p,
  input  logic       ci,
  output logic       eq
);

  assign eq = (p == CH_DOT) ? (t != CH_NUL) : (fold(t, ci) == fold(p, ci));

endmodule

// File: rtl/sme_multi_engine.sv
// Multi-pattern string-match engine. Scans a NUL-terminated text ROM for every
// pattern of a pattern ROM and reports each hit over a valid/ready handshake.
//   clk, reset        : clock, asynchronous active-high reset
//   case_insensitive  : latched once after reset release
//   T_addr / T_data   : text ROM, data arrives the cycle after the address
//   P_addr / P_data   : pattern ROM, same latency
//   pattern_no        : 0-based index of the matching pattern
//   match_addr        : text address of the first matched character
//   valid / out_ready : result handshake, result held until accepted
//   finish            : sticky, every pattern scanned and every result taken
//
// state | meaning
// IDLE  | latch case_insensitive, start at pattern 0
// LOAD  | read one pattern into the buffer, find anchors and length
// PRE   | pick next start s; for '^' check that text[s-1] is a space
// CMP   | compare text[s+k] with pat[k], one byte per fetch
// POST  | for '$' check that text[s+len] is NUL or space
// EMIT  | present result, wait for acceptance
// DONE  | all patterns processed, finish raised
//
// Every ROM read uses ph: the address is issued with ph=1, ph=2 is the cycle
// in which the synchronous ROM output is valid and consumed.
module sme_multi_engine
  import sme_pkg::*;
#(
  parameter int TW       = 12,
  parameter int PW       = 7,
  parameter int MAX_PAT  = 16,
  parameter int MAX_PLEN = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       case_insensitive,
  output logic [TW-1:0]              T_addr,
  input  logic [7:0]                 T_data,
  output logic [PW-1:0]              P_addr,
  input  logic [7:0]                 P_data,
  output logic [$clog2(MAX_PAT)-1:0] pattern_no,
  output logic [TW-1:0]              match_addr,
  output logic                       valid,
  input  logic                       out_ready,
  output logic                       finish
);

  localparam int NW = $clog2(MAX_PAT);
  localparam int KW = $clog2(MAX_PLEN);
  localparam int LW = $clog2(MAX_PLEN + 1);
  localparam int NL = $clog2(MAX_PLEN + 2);

  state_t        state;
  logic [1:0]    ph;
  logic          ci_r;
  logic [TW:0]   s;            // extra bit marks running off the end of the ROM
  logic [LW-1:0] k;
  logic [LW-1:0] plen;
  logic [NL-1:0] n;            // chars seen, saturates at MAX_PLEN+1
  logic [NW-1:0] pat_idx;
  logic          first;
  logic          last_dollar;
  logic          anc_caret;
  logic          anc_dollar;
  logic          t_over;       // current text fetch is past the last address
  logic [7:0]    pbuf [MAX_PLEN];

  logic [7:0]    t_byte;
  logic          eq;
  logic [NL-1:0] n_cur, n_inc, n_sub;
  logic [LW-1:0] len_calc;
  logic [TW:0]   a_nxt;
  logic [TW-1:0] s_m1;
  logic          buf_we;
  logic          list_end;
  logic          exhaust;

  sme_char_cmp u_cmp (
    .t  (t_byte),
    .p  (pbuf[k[KW-1:0]]),
    .ci (ci_r),
    .eq (eq)
  );

  assign t_byte   = t_over ? CH_NUL : T_data;
  assign n_cur    = first ? '0 : n;
  assign n_inc    = (n_cur == NL'(MAX_PLEN + 1)) ? n_cur : n_cur + NL'(1);
  // a trailing '$' was counted as a char while loading; drop it here
  assign n_sub    = last_dollar ? n - NL'(1) : n;
  assign len_calc = (n_sub > NL'(MAX_PLEN)) ? LW'(MAX_PLEN) : LW'(n_sub);
  assign a_nxt    = s + (TW+1)'(k) + (TW+1)'(1);
  assign s_m1     = s[TW-1:0] - TW'(1);
  assign list_end = (pat_idx == NW'(MAX_PAT - 1)) || (P_addr == {PW{1'b1}});
  assign buf_we   = (state == LOAD) && (ph == 2'd2) && (P_data != CH_NUL) &&
                    !(first && (P_data == CH_CARET)) && (n_cur < NL'(MAX_PLEN));

  // Current pattern is finished: text ran out, or pattern has no matchable chars.
  always_comb begin
    exhaust = 1'b0;
    case (state)
      LOAD:    exhaust = (ph == 2'd2) && (P_data == CH_NUL) && !first && (len_calc == '0);
      PRE:     exhaust = ((ph == 2'd0) && s[TW]) || ((ph == 2'd2) && (t_byte == CH_NUL));
      CMP:     exhaust = (ph == 2'd2) && (k == '0) && (t_byte == CH_NUL);
      default: exhaust = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (buf_we) pbuf[n_cur[KW-1:0]] <= P_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ph          <= 2'd0;
      ci_r        <= 1'b0;
      s           <= '0;
      k           <= '0;
      plen        <= '0;
      n           <= '0;
      pat_idx     <= '0;
      first       <= 1'b0;
      last_dollar <= 1'b0;
      anc_caret   <= 1'b0;
      anc_dollar  <= 1'b0;
      t_over      <= 1'b0;
      T_addr      <= '0;
      P_addr      <= '0;
      pattern_no  <= '0;
      match_addr  <= '0;
      valid       <= 1'b0;
      finish      <= 1'b0;
    end else if (exhaust) begin
      if (list_end) begin
        state  <= DONE;
        finish <= 1'b1;
      end else begin
        state   <= LOAD;
        ph      <= 2'd1;
        first   <= 1'b1;
        P_addr  <= P_addr + PW'(1);
        pat_idx <= pat_idx + NW'(1);
      end
    end else begin
      case (state)
        IDLE: begin
          ci_r  <= case_insensitive;
          state <= LOAD;
          ph    <= 2'd1;
          first <= 1'b1;
        end

        LOAD: begin
          if (ph != 2'd2) begin
            ph <= 2'd2;
          end else if (P_data == CH_NUL) begin
            if (first) begin
              // empty pattern terminates the list
              state  <= DONE;
              finish <= 1'b1;
            end else begin
              anc_dollar <= last_dollar;
              plen       <= len_calc;
              s          <= '0;
              state      <= PRE;
              ph         <= 2'd0;
            end
          end else begin
            first <= 1'b0;
            if (first) anc_caret <= (P_data == CH_CARET);
            if (first && (P_data == CH_CARET)) begin
              n           <= '0;
              last_dollar <= 1'b0;
            end else begin
              n           <= n_inc;
              last_dollar <= (P_data == CH_DOLLAR);
            end
            if (P_addr == {PW{1'b1}}) begin
              // unterminated pattern at the top of the ROM: stop
              state  <= DONE;
              finish <= 1'b1;
            end else begin
              P_addr <= P_addr + PW'(1);
              ph     <= 2'd1;
            end
          end
        end

        PRE: begin
          if (ph == 2'd0) begin
            t_over <= 1'b0;
            if (anc_caret && (s != '0)) begin
              T_addr <= s_m1;
              ph     <= 2'd1;
            end else begin
              T_addr <= s[TW-1:0];
              k      <= '0;
              state  <= CMP;
              ph     <= 2'd1;
            end
          end else if (ph == 2'd1) begin
            ph <= 2'd2;
          end else if (t_byte != CH_SP) begin
            s  <= s + (TW+1)'(1);
            ph <= 2'd0;
          end else begin
            T_addr <= s[TW-1:0];
            t_over <= 1'b0;
            k      <= '0;
            state  <= CMP;
            ph     <= 2'd1;
          end
        end

        CMP: begin
          if (ph == 2'd1) begin
            ph <= 2'd2;
          end else if (!eq) begin
            s     <= s + (TW+1)'(1);
            state <= PRE;
            ph    <= 2'd0;
          end else begin
            // next fetch is text[s+k+1]; after the last char that is the '$' probe
            T_addr <= a_nxt[TW-1:0];
            t_over <= a_nxt[TW];
            ph     <= 2'd1;
            k      <= k + LW'(1);
            if (k == plen - LW'(1)) begin
              if (anc_dollar) begin
                state <= POST;
              end else begin
                state      <= EMIT;
                valid      <= 1'b1;
                pattern_no <= pat_idx;
                match_addr <= s[TW-1:0];
              end
            end
          end
        end

        POST: begin
          if (ph == 2'd1) begin
            ph <= 2'd2;
          end else if ((t_byte == CH_NUL) || (t_byte == CH_SP)) begin
            state      <= EMIT;
            valid      <= 1'b1;
            pattern_no <= pat_idx;
            match_addr <= s[TW-1:0];
          end else begin
            s     <= s + (TW+1)'(1);
            state <= PRE;
            ph    <= 2'd0;
          end
        end

        EMIT: begin
          if (out_ready) begin
            valid <= 1'b0;
            s     <= s + (TW+1)'(1);
            state <= PRE;
            ph    <= 2'd0;
          end
        end

        DONE: begin
          finish <= 1'b1;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
